tx_xgmii_sched: RTL and testbench
=================================

Name: tx_xgmii_sched

Overview:
- TX-side sequencer sitting between the MAC frame stream and the 64b/66b encoder input (64-bit XGMII-style data plus per-lane control).
- Builds start, preamble/SFD, data, terminate and inter-packet idle words.
- Inserts link-signalling ordered sets when requested.
- Honours the gearbox pause and the PCS init-done qualifier, so the encoder only ever sees legal control patterns.

Parameters:
- IPG_WORDS, 1, idle words inserted after the word carrying (or following) TERMINATE; range 1..15.
- CNT_W, 16, width of the transmitted-frame counter.

Ports:
- i_txc  in  1  TX clock; all logic on its rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_init_done  in  1  PCS initialisation complete.
- i_tx_pause  in  1  gearbox pause; freezes all sequencing for that cycle.
- i_frm_valid  in  1  MAC beat valid.
- o_frm_ready  out  1  beat accepted when valid&ready.
- i_frm_data  in  64  payload bytes, byte 0 in [7:0] (first on the wire).
- i_frm_keep  in  8  lane-valid mask; all-ones except on the last beat.
- i_frm_last  in  1  last beat of frame.
- i_os_req  in  1  ordered-set request (level).
- i_os_data  in  24  ordered-set data bytes 1..3.
- o_os_ack  out  1  one-cycle pulse when an ordered-set word is issued.
- o_txd  out  64  word to encoder.
- o_txctl  out  8  per-lane control flags to encoder (1 = control character).
- o_frame_cnt  out  CNT_W  frames terminated, wraps modulo 2^CNT_W.

Behaviour:
- Codes used: IDLE 0x07, START 0xFB, TERM 0xFD, ERROR 0xFE, SEQ 0x9C; preamble 0x55; SFD 0xD5.
- Idle word: o_txd = 8 × 0x07, o_txctl = 0xFF.
- Error word: o_txd = 8 × 0xFE, o_txctl = 0xFF.
- Reset (async assert, sync release): state IDLE, o_txd = idle word, o_txctl = 0xFF, o_frm_ready = 0, o_os_ack = 0, o_frame_cnt = 0, IPG counter = 0.
- Output timing: o_txd/o_txctl/o_os_ack are registered. The word decided in cycle N appears in cycle N+1.
- o_frm_ready is combinational: state==DATA && i_init_done && !i_tx_pause.
- Pause: while i_tx_pause = 1:
  - outputs, state and counters hold;
  - o_frm_ready = 0;
  - o_os_ack = 0;
  - pending requests stay pending.
- FSM states IDLE, START, DATA, TERM, IPG. Transitions are evaluated only when !i_tx_pause && i_init_done.
- IDLE: emit idle word. Priority order:
  - if i_os_req: emit ordered-set word and pulse o_os_ack; stay IDLE.
  - else if i_frm_valid: go START (no beat consumed).
  - Ordered-set word: lane0 = 0x9C, lanes1-3 = i_os_data[7:0], [15:8], [23:16]; lanes4-7 repeat lanes0-3; o_txctl = 0x11.
  - Back-to-back requests produce back-to-back ordered-set words.
- START: emit {0xD5, 6 × 0x55, 0xFB} (lane0 = 0xFB), o_txctl = 0x01; go DATA.
- DATA, valid&ready, !last: emit i_frm_data, o_txctl = 0x00.
- DATA, valid&ready, last, keep = 2^k−1 with k in 1..7:
  - lanes 0..k−1 carry data, lane k = 0xFD, lanes above k = 0x07;
  - o_txctl = ~keep;
  - o_frame_cnt++; go IPG.
- DATA, valid&ready, last, keep = 0xFF: emit data (ctl 0x00); go TERM.
- DATA, last with keep = 0x00 or non-contiguous: emit error word; go TERM. This frame is not counted.
- DATA, !i_frm_valid (underrun): emit error word; stay DATA.
- TERM: emit {7 × 0x07, 0xFD}, o_txctl = 0xFF. Increment o_frame_cnt only if arriving from a keep = 0xFF last beat. Go IPG.
- IPG: emit IPG_WORDS idle words, counted down from IPG_WORDS−1 to 0; then go IDLE. i_os_req and i_frm_valid are ignored until IDLE.
- i_init_done = 0, any state:
  - next word is idle word, except from START/DATA/TERM, where one error word is emitted first;
  - then state IDLE; IPG counter cleared; o_frm_ready = 0; o_os_ack = 0.
- Pause coinciding with last beat: the beat is not accepted (ready low) and is accepted on the first unpaused cycle.
- Async reset mid-frame: all outputs return to reset values immediately. No TERMINATE is generated.

Test Plan:
- Reset release, i_init_done = 1, no requests → o_txd = 0x0707070707070707, o_txctl = 0xFF every cycle; o_frame_cnt = 0.
- Three-beat frame with last keep = 0x0F, IPG_WORDS = 1:
  - output sequence: START word (lane0 0xFB, ctl 0x01), beat0, beat1 (ctl 0x00);
  - then {0x07,0x07,0x07,0xFD, data[31:0]}, ctl 0xF0;
  - then one idle word; o_frame_cnt = 1.
- Last beat keep = 0xFF:
  - data word ctl 0x00, then TERM word {7 × 0x07, 0xFD} ctl 0xFF;
  - then IPG idle; o_frame_cnt increments once.
- i_os_req with i_os_data = 0x000001 and i_frm_valid both high in IDLE:
  - ordered-set word 0x0000019C0000019C, ctl 0x11, one-cycle o_os_ack;
  - frame START follows only after i_os_req drops.
- i_tx_pause held 3 cycles mid-frame → o_txd/o_txctl frozen, o_frm_ready = 0; the frame resumes with no lost or duplicated beat.
- i_init_done dropped during DATA → one error word (8 × 0xFE, ctl 0xFF), then idle words; state IDLE; o_frame_cnt unchanged.

Source files
------------

// File: rtl/tx_xgmii_sched.sv
// Purpose  : TX sequencer from MAC beats to 64-bit XGMII-style words (start, preamble/SFD, data,
//            terminate, inter-packet idle, ordered sets) for the 64b/66b encoder.
// Latency  : one cycle, the word decided in cycle N is on o_txd/o_txctl in cycle N+1.
// Backpres.: o_frm_ready only in DATA with init done and no gearbox pause; a pause freezes everything.
// Ports    : i_txc/i_reset_n clock and async active-low reset; i_init_done PCS qualifier;
//            i_tx_pause gearbox pause; i_frm_* MAC beat stream (valid/ready, data, keep, last);
//            i_os_req/i_os_data/o_os_ack ordered-set request; o_txd/o_txctl encoder word;
//            o_frame_cnt count of terminated frames.
module tx_xgmii_sched #(
   parameter int IPG_WORDS = 1,
   parameter int CNT_W     = 16
) (
   input  logic             i_txc,
   input  logic             i_reset_n,
   input  logic             i_init_done,
   input  logic             i_tx_pause,
   input  logic             i_frm_valid,
   output logic             o_frm_ready,
   input  logic [63:0]      i_frm_data,
   input  logic [7:0]       i_frm_keep,
   input  logic             i_frm_last,
   input  logic             i_os_req,
   input  logic [23:0]      i_os_data,
   output logic             o_os_ack,
   output logic [63:0]      o_txd,
   output logic [7:0]       o_txctl,
   output logic [CNT_W-1:0] o_frame_cnt
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_TERM  = 3'd3;
   localparam logic [2:0] ST_IPG   = 3'd4;

   localparam logic [63:0] W_IDLE  = {8{8'h07}};
   localparam logic [63:0] W_ERR   = {8{8'hFE}};
   localparam logic [63:0] W_START = {8'hD5, {6{8'h55}}, 8'hFB};
   localparam logic [63:0] W_TERM  = {{7{8'h07}}, 8'hFD};
   localparam logic [3:0]  IPG_RELOAD = 4'(IPG_WORDS - 1);

   logic [2:0]       state, state_nx;
   logic [63:0]      txd, txd_nx;
   logic [7:0]       txctl, txctl_nx;
   logic             os_ack_q, os_ack_nx;
   logic [CNT_W-1:0] frame_cnt, frame_cnt_nx;
   logic [3:0]       ipg_cnt, ipg_cnt_nx;
   // set when a full-width last beat was sent, so the following TERM word counts the frame
   logic             term_pend, term_pend_nx;

   logic             keep_contig;
   logic [63:0]      term_word;

   // keep is a non-empty run of ones from lane 0 (2^k-1) exactly when keep & (keep+1) is zero
   assign keep_contig = (i_frm_keep != 8'h00) && ((i_frm_keep & (i_frm_keep + 8'd1)) == 8'h00);

   // partial last beat: data lanes, TERMINATE in the first empty lane, idles above it
   always_comb begin
      term_word       = W_IDLE;
      term_word[7:0]  = i_frm_data[7:0];
      for (int i = 1; i < 8; i++) begin
         if (i_frm_keep[i])
            term_word[8*i +: 8] = i_frm_data[8*i +: 8];
         else if (i_frm_keep[i-1])
            term_word[8*i +: 8] = 8'hFD;
         else
            term_word[8*i +: 8] = 8'h07;
      end
   end

   always_comb begin
      state_nx     = state;
      txd_nx       = txd;
      txctl_nx     = txctl;
      os_ack_nx    = os_ack_q;
      frame_cnt_nx = frame_cnt;
      ipg_cnt_nx   = ipg_cnt;
      term_pend_nx = term_pend;
      if (!i_tx_pause) begin
         os_ack_nx = 1'b0;
         if (!i_init_done) begin
            // a frame in flight is poisoned with one error word before falling back to idle
            txd_nx       = (state == ST_START || state == ST_DATA || state == ST_TERM) ? W_ERR : W_IDLE;
            txctl_nx     = 8'hFF;
            state_nx     = ST_IDLE;
            ipg_cnt_nx   = 4'd0;
            term_pend_nx = 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  txd_nx   = W_IDLE;
                  txctl_nx = 8'hFF;
                  if (i_os_req) begin
                     txd_nx    = {2{i_os_data, 8'h9C}};
                     txctl_nx  = 8'h11;
                     os_ack_nx = 1'b1;
                  end else if (i_frm_valid) begin
                     state_nx = ST_START;
                  end
               end
               ST_START: begin
                  txd_nx   = W_START;
                  txctl_nx = 8'h01;
                  state_nx = ST_DATA;
               end
               ST_DATA: begin
                  if (!i_frm_valid) begin
                     // underrun: keep the frame open but mark it bad on the wire
                     txd_nx   = W_ERR;
                     txctl_nx = 8'hFF;
                  end else if (!i_frm_last) begin
                     txd_nx   = i_frm_data;
                     txctl_nx = 8'h00;
                  end else if (i_frm_keep == 8'hFF) begin
                     txd_nx       = i_frm_data;
                     txctl_nx     = 8'h00;
                     term_pend_nx = 1'b1;
                     state_nx     = ST_TERM;
                  end else if (keep_contig) begin
                     txd_nx       = term_word;
                     txctl_nx     = ~i_frm_keep;
                     frame_cnt_nx = frame_cnt + CNT_W'(1);
                     ipg_cnt_nx   = IPG_RELOAD;
                     state_nx     = ST_IPG;
                  end else begin
                     txd_nx       = W_ERR;
                     txctl_nx     = 8'hFF;
                     term_pend_nx = 1'b0;
                     state_nx     = ST_TERM;
                  end
               end
               ST_TERM: begin
                  txd_nx       = W_TERM;
                  txctl_nx     = 8'hFF;
                  if (term_pend)
                     frame_cnt_nx = frame_cnt + CNT_W'(1);
                  term_pend_nx = 1'b0;
                  ipg_cnt_nx   = IPG_RELOAD;
                  state_nx     = ST_IPG;
               end
               ST_IPG: begin
                  txd_nx   = W_IDLE;
                  txctl_nx = 8'hFF;
                  if (ipg_cnt == 4'd0)
                     state_nx = ST_IDLE;
                  else
                     ipg_cnt_nx = ipg_cnt - 4'd1;
               end
               default: begin
                  txd_nx   = W_IDLE;
                  txctl_nx = 8'hFF;
                  state_nx = ST_IDLE;
               end
            endcase
         end
      end
   end

   always_ff @(posedge i_txc or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state     <= ST_IDLE;
         txd       <= W_IDLE;
         txctl     <= 8'hFF;
         os_ack_q  <= 1'b0;
         frame_cnt <= '0;
         ipg_cnt   <= 4'd0;
         term_pend <= 1'b0;
      end else begin
         state     <= state_nx;
         txd       <= txd_nx;
         txctl     <= txctl_nx;
         os_ack_q  <= os_ack_nx;
         frame_cnt <= frame_cnt_nx;
         ipg_cnt   <= ipg_cnt_nx;
         term_pend <= term_pend_nx;
      end
   end

   assign o_txd       = txd;
   assign o_txctl     = txctl;
   assign o_frame_cnt = frame_cnt;
   // the ack register holds through a pause with its word; masking it keeps the
   // visible pulse to exactly one unpaused cycle
   assign o_os_ack    = os_ack_q & ~i_tx_pause;
   assign o_frm_ready = (state == ST_DATA) && i_init_done && !i_tx_pause;

endmodule

// File: tb/tb_tx_xgmii_sched.sv
// Purpose  : self-checking bench for tx_xgmii_sched, random stimulus against a word-level model.
// Latency  : model predicts the registered word one cycle after the deciding cycle.
// Backpres.: beats leave the bench queue only on predicted valid&ready.
module tb_tx_xgmii_sched;
   localparam int IPG   = 3;
   localparam int CNT_W = 16;
   localparam logic [63:0] W_IDLE = {8{8'h07}};

   localparam int PH_IDLE = 0, PH_START = 1, PH_DATA = 2, PH_TERM = 3, PH_GAP = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             init_done = 1'b0, tx_pause = 1'b0;
   logic             frm_valid = 1'b0, frm_ready, frm_last = 1'b0;
   logic [63:0]      frm_data = '0;
   logic [7:0]       frm_keep = 8'hFF;
   logic             os_req = 1'b0, os_ack;
   logic [23:0]      os_data = '0;
   logic [63:0]      txd;
   logic [7:0]       txctl;
   logic [CNT_W-1:0] frame_cnt;

   always #5 clk = ~clk;

   tx_xgmii_sched #(.IPG_WORDS(IPG), .CNT_W(CNT_W)) dut (
      .i_txc(clk), .i_reset_n(rst_n), .i_init_done(init_done), .i_tx_pause(tx_pause),
      .i_frm_valid(frm_valid), .o_frm_ready(frm_ready), .i_frm_data(frm_data),
      .i_frm_keep(frm_keep), .i_frm_last(frm_last), .i_os_req(os_req), .i_os_data(os_data),
      .o_os_ack(os_ack), .o_txd(txd), .o_txctl(txctl), .o_frame_cnt(frame_cnt)
   );

   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
   } beat_t;
   beat_t beat_q[$];

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // reference model: expected output word and bookkeeping in frame terms
   logic [63:0]      m_txd;
   logic [7:0]       m_ctl;
   logic             m_ack;
   logic [CNT_W-1:0] m_cnt;
   int               m_ph;
   int               m_gap;      // idle words still owed after a frame
   bit               m_pend;     // full-width last beat sent, TERM word closes the frame

   task automatic model_reset();
      m_txd = W_IDLE; m_ctl = 8'hFF; m_ack = 1'b0; m_cnt = '0;
      m_ph = PH_IDLE; m_gap = 0; m_pend = 1'b0;
   endtask

   task automatic model_step(input logic pause, input logic init, input logic req,
                             input logic [23:0] osd, input logic valid, input beat_t b);
      int k;
      if (pause) return;
      m_ack = 1'b0;
      if (!init) begin
         m_txd = (m_ph == PH_START || m_ph == PH_DATA || m_ph == PH_TERM) ? {8{8'hFE}} : W_IDLE;
         m_ctl = 8'hFF; m_ph = PH_IDLE; m_gap = 0; m_pend = 1'b0;
         return;
      end
      case (m_ph)
         PH_IDLE: begin
            m_txd = W_IDLE; m_ctl = 8'hFF;
            if (req) begin
               for (int i = 0; i < 8; i++)
                  m_txd[8*i +: 8] = (i % 4 == 0) ? 8'h9C : osd[8*((i % 4) - 1) +: 8];
               m_ctl = 8'h11; m_ack = 1'b1;
            end else if (valid) m_ph = PH_START;
         end
         PH_START: begin
            m_txd = 64'hD5555555555555FB; m_ctl = 8'h01; m_ph = PH_DATA;
         end
         PH_DATA: begin
            k = $countones(b.k);
            if (!valid) begin
               m_txd = {8{8'hFE}}; m_ctl = 8'hFF;
            end else if (!b.l || b.k == 8'hFF) begin
               m_txd = b.d; m_ctl = 8'h00;
               if (b.l) begin m_ph = PH_TERM; m_pend = 1'b1; end
            end else if (k > 0 && int'(b.k) == (1 << k) - 1) begin
               for (int i = 0; i < 8; i++)
                  m_txd[8*i +: 8] = (i < k) ? b.d[8*i +: 8] : ((i == k) ? 8'hFD : 8'h07);
               m_ctl = ~b.k; m_cnt = m_cnt + 1'b1; m_ph = PH_GAP; m_gap = IPG;
            end else begin
               m_txd = {8{8'hFE}}; m_ctl = 8'hFF; m_ph = PH_TERM; m_pend = 1'b0;
            end
         end
         PH_TERM: begin
            m_txd = 64'h07070707070707FD; m_ctl = 8'hFF;
            if (m_pend) m_cnt = m_cnt + 1'b1;
            m_pend = 1'b0; m_ph = PH_GAP; m_gap = IPG;
         end
         default: begin
            m_txd = W_IDLE; m_ctl = 8'hFF;
            m_gap--;
            if (m_gap == 0) m_ph = PH_IDLE;
         end
      endcase
   endtask

   task automatic push_frame();
      int n, sel;
      beat_t b;
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
         b.d = {$urandom, $urandom};
         b.k = 8'hFF;
         b.l = (i == n - 1);
         if (b.l) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)       b.k = 8'((1 << $urandom_range(1, 8)) - 1);
            else if (sel == 7) b.k = 8'h00;
            else               b.k = 8'($urandom);
         end
         beat_q.push_back(b);
      end
   endtask

   // one clock: drive after the falling edge, check combinational outputs,
   // advance the model, then check registered outputs at the next falling edge
   task automatic cycle(input logic pause, input logic init, input logic req,
                        input logic [23:0] osd, input logic valid_in);
      beat_t b;
      logic  valid, rdy;
      b = '0;
      valid = valid_in && (beat_q.size() > 0);
      if (beat_q.size() > 0) b = beat_q[0];
      tx_pause = pause; init_done = init; os_req = req; os_data = osd;
      frm_valid = valid; frm_data = b.d; frm_keep = b.k; frm_last = b.l;
      #1;
      rdy = (m_ph == PH_DATA) && init && !pause;
      chk("frm_ready", frm_ready, rdy);
      chk("os_ack", os_ack, m_ack && !pause);
      model_step(pause, init, req, osd, valid, b);
      if (rdy && valid) void'(beat_q.pop_front());
      @(negedge clk);
      chk("txd", txd, m_txd);
      chk("txctl", txctl, m_ctl);
      chk("frame_cnt", frame_cnt, m_cnt);
   endtask

   logic        r_init, r_req;
   logic [23:0] r_osd;
   int          guard;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_txd", txd, W_IDLE);
      chk("rst_txctl", txctl, 8'hFF);
      chk("rst_ready", frm_ready, 1'b0);
      chk("rst_ack", os_ack, 1'b0);
      chk("rst_cnt", frame_cnt, '0);
      model_reset();
      rst_n = 1'b1;

      repeat (5) cycle(1'b0, 1'b1, 1'b0, 24'h0, 1'b0);

      // ordered set wins over a waiting frame
      push_frame();
      cycle(1'b0, 1'b1, 1'b1, 24'h000001, 1'b1);
      chk("os_word", txd, 64'h0000019C0000019C);
      chk("os_ctl", txctl, 8'h11);
      repeat (12) cycle(1'b0, 1'b1, 1'b0, 24'h0, 1'b1);

      r_init = 1'b1; r_req = 1'b0; r_osd = '0;
      for (int n = 0; n < 4000; n++) begin
         if (beat_q.size() == 0) push_frame();
         if (r_init && $urandom_range(0, 199) == 0) r_init = 1'b0;
         else if (!r_init && $urandom_range(0, 3) == 0) r_init = 1'b1;
         if (r_req && m_ack && $urandom_range(0, 1) == 0) r_req = 1'b0;
         else if (!r_req && $urandom_range(0, 39) == 0) begin
            r_req = 1'b1; r_osd = 24'($urandom);
         end
         cycle($urandom_range(0, 9) == 0, r_init, r_req, r_osd, $urandom_range(0, 7) != 0);
      end

      // async reset in the middle of a frame
      guard = 0;
      while (m_ph != PH_DATA && guard < 40) begin
         if (beat_q.size() == 0) push_frame();
         cycle(1'b0, 1'b1, 1'b0, 24'h0, 1'b1);
         guard++;
      end
      chk("reach_data", guard < 40, 1'b1);
      cycle(1'b0, 1'b1, 1'b0, 24'h0, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_txd", txd, W_IDLE);
      chk("arst_txctl", txctl, 8'hFF);
      chk("arst_ready", frm_ready, 1'b0);
      chk("arst_ack", os_ack, 1'b0);
      chk("arst_cnt", frame_cnt, '0);
      model_reset();
      beat_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) cycle(1'b0, 1'b1, 1'b0, 24'h0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
